// File: rtl/osd0_engine.sv
// Ordered-statistics (order-0) decoder engine: sorts columns by reliability, builds a GF(2) basis in
// that order and solves the syndrome over the pivot columns. Define OSD_EARLY_STOP_EN to end elimination at full rank.
module osd0_engine #(
    parameter int DATA_WIDTH       = 32,
    parameter int NUM_OF_ENTERIES  = 8,
    parameter int H_ROW_SIZE       = 4,
    localparam int INDEX_SIZE      = $clog2(NUM_OF_ENTERIES)
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               vld_in,
    output logic                               in_ready,
    input  logic [DATA_WIDTH-1:0]              llr,
    input  logic [H_ROW_SIZE-1:0]              syndrome,
    output logic [INDEX_SIZE-1:0]              H_col_index,
    input  logic [H_ROW_SIZE-1:0]              H_col,
    output logic                               vld_out,
    output logic [NUM_OF_ENTERIES-1:0]         e_hat,
    output logic                               solve_fail,
    output logic [$clog2(H_ROW_SIZE+1)-1:0]    rank
);

    localparam int N  = NUM_OF_ENTERIES;
    localparam int M  = H_ROW_SIZE;
    localparam int RW = $clog2(H_ROW_SIZE + 1);
    localparam int LW = (M > 1) ? $clog2(M) : 1;
    localparam logic [INDEX_SIZE-1:0] LAST_IDX = INDEX_SIZE'(N - 1);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_ELIM    = 2'd1,
        ST_SOLVE   = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [INDEX_SIZE-1:0]   cnt_q, cnt_d;
    logic [INDEX_SIZE-1:0]   pos_q, pos_d;
    logic [M-1:0]            syn_q, syn_d;
    logic [DATA_WIDTH-1:0]   llr_q [N];
    logic [DATA_WIDTH-1:0]   llr_d [N];
    logic [INDEX_SIZE-1:0]   idx_q [N];
    logic [INDEX_SIZE-1:0]   idx_d [N];
    logic [M-1:0]            bval_q, bval_d;
    logic [M-1:0]            bvec_q [M];
    logic [M-1:0]            bvec_d [M];
    logic [N-1:0]            bmask_q [M];
    logic [N-1:0]            bmask_d [M];
    logic [RW-1:0]           bcnt_q, bcnt_d;
    logic [INDEX_SIZE-1:0]   h_idx_q, h_idx_d;
    logic                    in_ready_q, in_ready_d;
    logic                    vld_out_q, vld_out_d;
    logic [N-1:0]            e_hat_q, e_hat_d;
    logic                    fail_q, fail_d;
    logic [RW-1:0]           rank_q, rank_d;

    logic [N-1:0]            keep_s;
    logic [DATA_WIDTH-1:0]   ins_llr_s [N];
    logic [INDEX_SIZE-1:0]   ins_idx_s [N];
    logic [M-1:0]            res_vec_s;
    logic [N-1:0]            res_msk_s;
    logic                    res_nz_s;
    logic [LW-1:0]           lead_s;
    logic [N-1:0]            col_onehot_s;
    logic [RW-1:0]           bcnt_nxt_s;
    logic                    early_s;
    logic                    last_pos_s;

    // Insertion of the incoming beat: existing entries with llr >= new stay ahead (ties keep arrival order).
    always_comb begin
        for (int i = 0; i < N; i++) begin
            keep_s[i] = (INDEX_SIZE'(i) < cnt_q) && (llr_q[i] >= llr);
        end
        ins_llr_s[0] = keep_s[0] ? llr_q[0] : llr;
        ins_idx_s[0] = keep_s[0] ? idx_q[0] : cnt_q;
        for (int i = 1; i < N; i++) begin
            ins_llr_s[i] = keep_s[i] ? llr_q[i] : (keep_s[i-1] ? llr : llr_q[i-1]);
            ins_idx_s[i] = keep_s[i] ? idx_q[i] : (keep_s[i-1] ? cnt_q : idx_q[i-1]);
        end
    end

    // Reduce H_col (ELIM) or the captured syndrome (SOLVE) against the basis, slot p owns leading bit p.
    always_comb begin
        logic [M-1:0] v;
        logic [N-1:0] m;
        v = (state_q == ST_SOLVE) ? syn_q : H_col;
        m = {N{1'b0}};
        for (int p = M - 1; p >= 0; p--) begin
            if (v[p] && bval_q[p]) begin
                v = v ^ bvec_q[p];
                m = m ^ bmask_q[p];
            end else begin
                v = v;
                m = m;
            end
        end
        lead_s = {LW{1'b0}};
        for (int p = 0; p < M; p++) begin
            if (v[p]) begin
                lead_s = LW'(p);
            end else begin
                lead_s = lead_s;
            end
        end
        res_vec_s    = v;
        res_msk_s    = m;
        res_nz_s     = |v;
        col_onehot_s = {{(N-1){1'b0}}, 1'b1} << h_idx_q;
        bcnt_nxt_s   = res_nz_s ? (bcnt_q + RW'(1)) : bcnt_q;
        last_pos_s   = (pos_q == LAST_IDX);
`ifdef OSD_EARLY_STOP_EN
        early_s      = (bcnt_nxt_s == RW'(M));
`else
        early_s      = 1'b0;
`endif
    end

    // Next-state and datapath updates for the four-phase frame sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pos_d      = pos_q;
        syn_d      = syn_q;
        llr_d      = llr_q;
        idx_d      = idx_q;
        bval_d     = bval_q;
        bvec_d     = bvec_q;
        bmask_d    = bmask_q;
        bcnt_d     = bcnt_q;
        h_idx_d    = h_idx_q;
        in_ready_d = in_ready_q;
        vld_out_d  = vld_out_q;
        e_hat_d    = e_hat_q;
        fail_d     = fail_q;
        rank_d     = rank_q;
        case (state_q)
            ST_COLLECT: begin
                if (vld_in && in_ready_q) begin
                    llr_d = ins_llr_s;
                    idx_d = ins_idx_s;
                    syn_d = (cnt_q == {INDEX_SIZE{1'b0}}) ? syndrome : syn_q;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = {INDEX_SIZE{1'b0}};
                        pos_d      = {INDEX_SIZE{1'b0}};
                        h_idx_d    = ins_idx_s[0];
                        in_ready_d = 1'b0;
                        state_d    = ST_ELIM;
                    end else begin
                        cnt_d = cnt_q + INDEX_SIZE'(1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_ELIM: begin
                if (res_nz_s) begin
                    bval_d[lead_s]  = 1'b1;
                    bvec_d[lead_s]  = res_vec_s;
                    bmask_d[lead_s] = res_msk_s ^ col_onehot_s;
                end else begin
                    bval_d = bval_q;
                end
                bcnt_d = bcnt_nxt_s;
                if (last_pos_s || early_s) begin
                    state_d = ST_SOLVE;
                end else begin
                    pos_d   = pos_q + INDEX_SIZE'(1);
                    h_idx_d = idx_q[pos_q + INDEX_SIZE'(1)];
                end
            end
            ST_SOLVE: begin
                if (res_nz_s) begin
                    e_hat_d = {N{1'b0}};
                    fail_d  = 1'b1;
                end else begin
                    e_hat_d = res_msk_s;
                    fail_d  = 1'b0;
                end
                rank_d    = bcnt_q;
                vld_out_d = 1'b1;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                vld_out_d  = 1'b0;
                in_ready_d = 1'b1;
                bval_d     = {M{1'b0}};
                bcnt_d     = {RW{1'b0}};
                state_d    = ST_COLLECT;
            end
            default: begin
                vld_out_d  = 1'b0;
                in_ready_d = 1'b1;
                state_d    = ST_COLLECT;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_COLLECT;
            cnt_q      <= {INDEX_SIZE{1'b0}};
            pos_q      <= {INDEX_SIZE{1'b0}};
            syn_q      <= {M{1'b0}};
            for (int i = 0; i < N; i++) begin
                llr_q[i] <= {DATA_WIDTH{1'b0}};
                idx_q[i] <= {INDEX_SIZE{1'b0}};
            end
            bval_q     <= {M{1'b0}};
            for (int p = 0; p < M; p++) begin
                bvec_q[p]  <= {M{1'b0}};
                bmask_q[p] <= {N{1'b0}};
            end
            bcnt_q     <= {RW{1'b0}};
            h_idx_q    <= {INDEX_SIZE{1'b0}};
            in_ready_q <= 1'b1;
            vld_out_q  <= 1'b0;
            e_hat_q    <= {N{1'b0}};
            fail_q     <= 1'b0;
            rank_q     <= {RW{1'b0}};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pos_q      <= pos_d;
            syn_q      <= syn_d;
            llr_q      <= llr_d;
            idx_q      <= idx_d;
            bval_q     <= bval_d;
            bvec_q     <= bvec_d;
            bmask_q    <= bmask_d;
            bcnt_q     <= bcnt_d;
            h_idx_q    <= h_idx_d;
            in_ready_q <= in_ready_d;
            vld_out_q  <= vld_out_d;
            e_hat_q    <= e_hat_d;
            fail_q     <= fail_d;
            rank_q     <= rank_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign H_col_index = h_idx_q;
    assign vld_out     = vld_out_q;
    assign e_hat       = e_hat_q;
    assign solve_fail  = fail_q;
    assign rank        = rank_q;

endmodule

// File: doc/osd0_engine.md
OSD0_ENGINE -- requirements
Module: osd0_engine

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, meaning unsigned reliability word width.
REQ-002 SHALL have parameter NUM_OF_ENTERIES, default 8, meaning number of H columns (N) per frame, N>=2.
REQ-003 SHALL have parameter H_ROW_SIZE, default 4, meaning number of H rows/syndrome bits (M).
REQ-004 SHALL have derived localparam INDEX_SIZE = $clog2(NUM_OF_ENTERIES), the column index width.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port vld_in  input  1  input beat valid.
REQ-008 SHALL have port in_ready  output  1  engine accepts beats.
REQ-009 SHALL have port llr  input  DATA_WIDTH  error-likelihood value of the current column.
REQ-010 SHALL have port syndrome  input  H_ROW_SIZE  target syndrome, sampled on beat 0.
REQ-011 SHALL have port H_col_index  output  INDEX_SIZE  original index of the column requested.
REQ-012 SHALL have port H_col  input  H_ROW_SIZE  column for H_col_index, valid combinationally in the same cycle.
REQ-013 SHALL have port vld_out  output  1  one-cycle result strobe.
REQ-014 SHALL have port e_hat  output  NUM_OF_ENTERIES  error estimate, bit i = original column i.
REQ-015 SHALL have port solve_fail  output  1  syndrome not in span of selected columns.
REQ-016 SHALL have port rank  output  $clog2(H_ROW_SIZE+1)  number of pivot columns found.

Function
REQ-017 SHALL implement states COLLECT, ELIM, SOLVE, DONE; in_ready=1 only in COLLECT.
REQ-018 COLLECT: beat accepted when vld_in&&in_ready; k-th accepted beat (k=0..N-1) gets original index k; vld_in with in_ready=0 ignored.
REQ-019 Each accepted beat SHALL be inserted into a registered sorted list at that edge: descending unsigned llr, ties ordered by lower original index; after beat N-1 -> ELIM.
REQ-020 ELIM: one column per cycle in sorted order (position j drives H_col_index from a register); H_col reduced against current basis; nonzero residual becomes a new pivot with its original index tracked; zero residual discarded.
REQ-021 ELIM SHALL end after position N-1, or per REQ-029; then SOLVE.
REQ-022 SOLVE (one cycle): reduce syndrome against basis; residual zero -> e_hat = OR-mask of original indices of pivot columns used, solve_fail=0; else e_hat=0, solve_fail=1; rank registered.
REQ-023 DONE: vld_out=1 exactly one cycle, then COLLECT; e_hat/solve_fail/rank hold until next SOLVE.
REQ-024 Latency: vld_out asserted (ELIM cycles)+2 cycles after the edge accepting beat N-1; full scan = N+2.
REQ-025 Boundaries: syndrome 0 -> e_hat 0, fail 0; all-zero H -> rank 0; rank never exceeds M; back-to-back frames accepted the cycle after vld_out.

Reset
REQ-026 rst_n low SHALL asynchronously force COLLECT, clear sorted list, basis, beat counter; in_ready=1 (while rst_n high), vld_out=0, e_hat=0, solve_fail=0, rank=0, H_col_index=0.
REQ-027 Reset mid-frame SHALL discard the frame entirely; no vld_out for it.

Configuration
REQ-028 Macro OSD_EARLY_STOP_EN SHALL select elimination termination.
REQ-029 Defined: ELIM ends the cycle rank reaches H_ROW_SIZE (remaining columns not fetched); undefined: all N columns always fetched; e_hat identical in both.

Verification
REQ-030 H cols idx0..7 = 1010,0110,1001,0101,1101,1010,0110,0001; llr BAE147AE,26666666,EB851EB8,7AE147AE,4F5C28F5,DC28F5C2,0A3D70A3,AB851EB8; syndrome 1011 -> e_hat 10100000, fail 0, rank 4; fetch order 2,5,0,7,3 (early-stop) or 2,5,0,7,3,4,1,6.
REQ-031 Same H/llr, syndrome 0000 -> e_hat 00000000, fail 0.
REQ-032 All columns 0001, syndrome 0010 -> solve_fail 1, e_hat 0, rank 1.
REQ-033 All llr equal -> H_col_index sequence 0,1,2,... ; vld_in held high during ELIM -> in_ready 0, frame unaffected.
REQ-034 rst_n pulsed low mid-ELIM, then REQ-030 frame resent -> no stray vld_out, REQ-030 result.
REQ-035 Two REQ-030 frames back-to-back -> two vld_out pulses N+2 (no early stop) cycles after each last beat, both e_hat 10100000.
